// File: rtl/powlib_ipsaxi_wr_pkg.sv
// powlib_ipsaxi_wr_pkg
//   Shared AXI field widths, burst/response encodings and the FSM state type
//   used by the AXI4 slave write endpoint and its address generator.
package powlib_ipsaxi_wr_pkg;

  // Bits per byte; the address width defaults to this times bytes per word.
  localparam int POWLIB_BW = 8;

  // AXI4 field widths.
  localparam int AXI_LENW   = 8;
  localparam int AXI_SIZEW  = 3;
  localparam int AXI_BURSTW = 2;
  localparam int AXI_RESPW  = 2;

  // AXI4 burst type encodings.
  localparam logic [AXI_BURSTW-1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [AXI_BURSTW-1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [AXI_BURSTW-1:0] AXI_BURST_WRAP  = 2'b10;

  // AXI4 response encodings.
  localparam logic [AXI_RESPW-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESPW-1:0] AXI_RESP_SLVERR = 2'b10;

  // Write endpoint FSM: take AW, stream W beats, wait for the output
  // register to empty, then hold B until it is accepted.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } wrState_t;

  // Only FIXED and INCR are executed natively; anything else is walked as
  // INCR and flagged as an error in the burst response.
  function automatic logic burstSupported(input logic [AXI_BURSTW-1:0] burst);
    return (burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR);
  endfunction

endpackage

// File: rtl/powlib_ipsaxi_addrgen.sv
// powlib_ipsaxi_addrgen
//   Holds the address of the current beat of a write burst and steps it once
//   per accepted W beat.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load_i         AW accepted: capture addr_i/size_i/burst_i
//   addr_i         burst start address
//   size_i         log2 bytes per beat
//   burst_i        burst type
//   advance_i      W beat accepted: step to the next beat address
//   addr_o         address of the beat about to be accepted
module powlib_ipsaxi_addrgen
  import powlib_ipsaxi_wr_pkg::*;
#(
  parameter int B_AW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [B_AW-1:0]       addr_i,
  input  logic [AXI_SIZEW-1:0]  size_i,
  input  logic [AXI_BURSTW-1:0] burst_i,
  input  logic                  advance_i,
  output logic [B_AW-1:0]       addr_o
);

  logic [B_AW-1:0]       addr_q;
  logic [AXI_SIZEW-1:0]  size_q;
  logic [AXI_BURSTW-1:0] burst_q;

  logic [B_AW-1:0] stepBytes;
  logic [B_AW-1:0] incrAddr;
  logic [B_AW-1:0] addr_d;

  // INCR aligns the current address down to the beat size before stepping,
  // so an unaligned start address only affects the first beat. The add
  // wraps naturally at 2^B_AW. FIXED keeps the address; WRAP and reserved
  // bursts fall back to INCR.
  always_comb begin
    stepBytes = {{(B_AW-1){1'b0}}, 1'b1} << size_q;
    incrAddr  = (addr_q & ~(stepBytes - {{(B_AW-1){1'b0}}, 1'b1})) + stepBytes;
    addr_d    = addr_q;
    if (load_i) begin
      addr_d = addr_i;
    end else if (advance_i) begin
      addr_d = (burst_q == AXI_BURST_FIXED) ? addr_q : incrAddr;
    end
  end

  // Address register plus the burst attributes captured at AW time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      size_q  <= '0;
      burst_q <= AXI_BURST_FIXED;
    end else begin
      addr_q <= addr_d;
      if (load_i) begin
        size_q  <= size_i;
        burst_q <= burst_i;
      end
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/powlib_ipsaxi_wr.sv
// powlib_ipsaxi_wr
//   AXI4 slave write-channel endpoint. Accepts one AW burst at a time,
//   forwards every W beat as a powlib write beat through a one-deep output
//   register, and returns a single B response once the last beat of the
//   burst has been taken downstream.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   awaddr/awlen/awsize/awburst     AW payload
//   awvalid/awready                 AW handshake
//   wdata/wstrb/wlast               W payload
//   wvalid/wready                   W handshake
//   bresp/bvalid/bready             B channel
//   wraddr/wrdata/wrbe              downstream beat address/data/byte enables
//   wrvld/wrrdy                     downstream beat handshake
// Parameters:
//   ID, EAR, EDBG                   kept for compatibility with the matching master
//   B_BPD                           bytes per data word (power of 2)
//   B_AW                            address width in bits
module powlib_ipsaxi_wr
  import powlib_ipsaxi_wr_pkg::*;
#(
  parameter string ID    = "IPSAXI_WR",
  parameter int    EAR   = 0,
  parameter int    EDBG  = 0,
  parameter int    B_BPD = 4,
  parameter int    B_AW  = POWLIB_BW * B_BPD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [B_AW-1:0]       awaddr,
  input  logic [AXI_LENW-1:0]   awlen,
  input  logic [AXI_SIZEW-1:0]  awsize,
  input  logic [AXI_BURSTW-1:0] awburst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [B_BPD*8-1:0]    wdata,
  input  logic [B_BPD-1:0]      wstrb,
  input  logic                  wlast,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [AXI_RESPW-1:0]  bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [B_AW-1:0]       wraddr,
  output logic [B_BPD*8-1:0]    wrdata,
  output logic [B_BPD-1:0]      wrbe,
  output logic                  wrvld,
  input  logic                  wrrdy
);

  // Largest beat size the data path can carry.
  localparam int BPD_LOG2 = (B_BPD > 1) ? $clog2(B_BPD) : 0;
  localparam logic [AXI_SIZEW-1:0] MAX_SIZE = AXI_SIZEW'(BPD_LOG2);

  wrState_t state_q, state_d;

  logic                 awready_q, awready_d;
  logic [AXI_LENW-1:0]  len_q, len_d;
  logic [AXI_LENW-1:0]  cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 sizeErr_q, sizeErr_d;
  logic [B_AW-1:0]      wraddr_q, wraddr_d;
  logic [B_BPD*8-1:0]   wrdata_q, wrdata_d;
  logic [B_BPD-1:0]     wrbe_q, wrbe_d;
  logic                 wrvld_q, wrvld_d;
  logic                 bvalid_q, bvalid_d;
  logic [AXI_RESPW-1:0] bresp_q, bresp_d;

  logic            wreadyC;
  logic            awHs;
  logic            wHs;
  logic            lastBeat;
  logic            sizeTooBig;
  logic            agLoad;
  logic            agAdvance;
  logic [B_AW-1:0] agAddr;

  powlib_ipsaxi_addrgen #(
    .B_AW(B_AW)
  ) uAddrgen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (agLoad),
    .addr_i    (awaddr),
    .size_i    (awsize),
    .burst_i   (awburst),
    .advance_i (agAdvance),
    .addr_o    (agAddr)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath decode. The beat counter, not wlast, ends a
  // burst; a wlast that disagrees with the counter only poisons the
  // response. An oversized awsize still consumes every beat but keeps wrvld
  // low so nothing is written downstream.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    sizeErr_d = sizeErr_q;
    wraddr_d  = wraddr_q;
    wrdata_d  = wrdata_q;
    wrbe_d    = wrbe_q;
    wrvld_d   = wrvld_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wreadyC   = 1'b0;
    wHs       = 1'b0;
    agLoad    = 1'b0;
    agAdvance = 1'b0;

    awHs       = awready_q && awvalid;
    lastBeat   = (cnt_q == len_q);
    sizeTooBig = (awsize > MAX_SIZE);

    if (wrvld_q && wrrdy) begin
      wrvld_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (awHs) begin
          state_d   = ST_DATA;
          len_d     = awlen;
          cnt_d     = '0;
          sizeErr_d = sizeTooBig;
          err_d     = sizeTooBig || !burstSupported(awburst);
          agLoad    = 1'b1;
        end
      end

      ST_DATA: begin
        wreadyC = !wrvld_q || wrrdy;
        wHs     = wvalid && wreadyC;
        if (wHs) begin
          wraddr_d  = agAddr;
          wrdata_d  = wdata;
          wrbe_d    = wstrb;
          wrvld_d   = !sizeErr_q;
          cnt_d     = cnt_q + AXI_LENW'(1);
          agAdvance = 1'b1;
          if (wlast != lastBeat) begin
            err_d = 1'b1;
          end
          if (lastBeat) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (!wrvld_q || wrrdy) begin
          bvalid_d = 1'b1;
          bresp_d  = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          state_d  = ST_RESP;
        end
      end

      ST_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    awready_d = (state_d == ST_IDLE);
  end

  // Burst bookkeeping, output beat register and B channel registers.
  // awready is registered so it is low throughout reset and rises the
  // cycle after the B handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awready_q <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      sizeErr_q <= 1'b0;
      wraddr_q  <= '0;
      wrdata_q  <= '0;
      wrbe_q    <= '0;
      wrvld_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      awready_q <= awready_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      sizeErr_q <= sizeErr_d;
      wraddr_q  <= wraddr_d;
      wrdata_q  <= wrdata_d;
      wrbe_q    <= wrbe_d;
      wrvld_q   <= wrvld_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wreadyC;
  assign wraddr  = wraddr_q;
  assign wrdata  = wrdata_q;
  assign wrbe    = wrbe_q;
  assign wrvld   = wrvld_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_powlib_ipsaxi_wr.sv
// tb_powlib_ipsaxi_wr
//   Directed bench for the AXI4 slave write endpoint: INCR and FIXED bursts,
//   downstream back-pressure, wlast and awsize errors, reset mid-burst and a
//   multi-burst 200-word stream with a slow B acceptor.
module tb_powlib_ipsaxi_wr;
  import powlib_ipsaxi_wr_pkg::*;

  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] wraddr;
  logic [31:0] wrdata;
  logic [3:0]  wrbe;
  logic        wrvld;
  logic        wrrdy;

  int checkCount = 0;
  int failCount  = 0;
  int cyc        = 0;
  int rdyMode    = 0;
  int bMode      = 0;
  int bWait      = 0;
  int bCount     = 0;
  int awEdge     = 0;
  int bEdge      = 0;
  int holdViol   = 0;
  logic [1:0] lastBresp = 2'b00;
  logic [1:0] prevBresp = 2'b00;
  logic       prevBWait = 1'b0;

  logic [31:0] obsAddr[$];
  logic [31:0] obsData[$];
  logic [3:0]  obsBe[$];
  int          obsCyc[$];

  logic [3:0] strbTab [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h8, 4'hC, 4'hE, 4'h5};

  powlib_ipsaxi_wr dut (
    .clk     (clk),
    .rst     (rst),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awburst (awburst),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .wraddr  (wraddr),
    .wrdata  (wrdata),
    .wrbe    (wrbe),
    .wrvld   (wrvld),
    .wrrdy   (wrrdy)
  );

  // 10 ns clock and a free-running edge counter.
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready: always ready, or toggling every cycle.
  initial begin
    wrrdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdyMode == 0) wrrdy = 1'b1;
      else              wrrdy = ~wrrdy;
    end
  end

  // B acceptor: immediate, or three cycles of stalling per response.
  initial begin
    bready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bMode == 0) begin
        bready = 1'b1;
      end else if (bvalid && !bready) begin
        if (bWait == 3) begin
          bready = 1'b1;
          bWait  = 0;
        end else begin
          bWait++;
        end
      end else begin
        bready = 1'b0;
      end
    end
  end

  // Monitor: inputs change 1 ns after posedge, so at negedge every
  // handshake that will happen on the next posedge is already visible.
  always @(negedge clk) begin
    if (rst) begin
      prevBWait = 1'b0;
    end else begin
      if (wrvld && wrrdy) begin
        obsAddr.push_back(wraddr);
        obsData.push_back(wrdata);
        obsBe.push_back(wrbe);
        obsCyc.push_back(cyc + 1);
      end
      if (awvalid && awready) awEdge = cyc + 1;
      if (bvalid && bready) begin
        bCount++;
        lastBresp = bresp;
        bEdge     = cyc + 1;
      end
      if (prevBWait && (!bvalid || bresp != prevBresp)) holdViol++;
      prevBWait = bvalid && !bready;
      prevBresp = bresp;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clearObs();
    obsAddr.delete();
    obsData.delete();
    obsBe.delete();
    obsCyc.delete();
  endtask

  // All driver tasks start and end 1 ns after a posedge.
  task automatic applyAw(input logic [31:0] a, input logic [7:0] l,
                         input logic [2:0] s, input logic [1:0] b);
    int n = 0;
    awaddr  = a;
    awlen   = l;
    awsize  = s;
    awburst = b;
    awvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (awready) break;
      n++;
      if (n > TMO) begin
        checkOutput("awTimeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    awvalid = 1'b0;
  endtask

  task automatic applyBeat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n = 0;
    wdata  = d;
    wstrb  = s;
    wlast  = l;
    wvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (wready) break;
      n++;
      if (n > TMO) begin
        checkOutput("wTimeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic waitB(input int target);
    int n = 0;
    while (bCount < target) begin
      @(posedge clk);
      #1;
      n++;
      if (n > TMO) begin
        checkOutput("bTimeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  // One complete burst: AW, len+1 W beats (wlast on beat lastIdx), then B.
  task automatic applyStimulus(input logic [31:0] a, input int len, input logic [2:0] s,
                               input logic [1:0] b, input int lastIdx,
                               input logic [31:0] dBase, input bit strbVary);
    int target = bCount + 1;
    applyAw(a, 8'(len), s, b);
    checkOutput("awreadyLowInBurst", 32'(awready), 32'd0);
    for (int i = 0; i <= len; i++) begin
      applyBeat(dBase + 32'(i), strbVary ? strbTab[i % 8] : 4'hF, i == lastIdx);
    end
    waitB(target);
    checkOutput("awreadyAfterB", 32'(awready), 32'd1);
  endtask

  task automatic checkBeats(input string tag, input int n, input logic [31:0] base,
                            input logic [31:0] step, input logic [31:0] dBase,
                            input bit strbVary);
    checkOutput({tag, "_count"}, 32'(obsAddr.size()), 32'(n));
    for (int i = 0; i < n && i < obsAddr.size(); i++) begin
      checkOutput({tag, "_addr"}, obsAddr[i], base + 32'(i) * step);
      checkOutput({tag, "_data"}, obsData[i], dBase + 32'(i));
      checkOutput({tag, "_be"}, 32'(obsBe[i]), 32'(strbVary ? strbTab[i % 8] : 4'hF));
    end
  endtask

  initial begin
    int bBefore;
    rst     = 1'b1;
    awaddr  = '0;
    awlen   = '0;
    awsize  = '0;
    awburst = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wlast   = 1'b0;
    wvalid  = 1'b0;

    // Reset values.
    #23;
    checkOutput("rst_awready", 32'(awready), 32'd0);
    checkOutput("rst_wready", 32'(wready), 32'd0);
    checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
    checkOutput("rst_bresp", 32'(bresp), 32'(AXI_RESP_OKAY));
    checkOutput("rst_wrvld", 32'(wrvld), 32'd0);
    checkOutput("rst_wraddr", wraddr, 32'd0);
    checkOutput("rst_wrdata", wrdata, 32'd0);
    checkOutput("rst_wrbe", 32'(wrbe), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Test 1: INCR 0x100, 4 beats, full throughput.
    $display("[TB] test 1: INCR burst");
    clearObs();
    applyStimulus(32'h100, 3, 3'd2, AXI_BURST_INCR, 3, 32'h1111_0000, 1'b0);
    checkBeats("t1", 4, 32'h100, 32'd4, 32'h1111_0000, 1'b0);
    if (obsCyc.size() >= 4) begin
      checkOutput("t1_latency", 32'(obsCyc[0] - awEdge), 32'd2);
      for (int i = 1; i < 4; i++) checkOutput("t1_consecutive", 32'(obsCyc[i] - obsCyc[i-1]), 32'd1);
      checkOutput("t1_bAfterLast", 32'(bEdge > obsCyc[3]), 32'd1);
    end
    checkOutput("t1_bcount", 32'(bCount), 32'd1);
    checkOutput("t1_bresp", 32'(lastBresp), 32'(AXI_RESP_OKAY));

    // Test 2: same burst, downstream ready toggling.
    $display("[TB] test 2: toggling wrrdy");
    rdyMode = 1;
    clearObs();
    applyStimulus(32'h100, 3, 3'd2, AXI_BURST_INCR, 3, 32'h2222_0000, 1'b0);
    checkBeats("t2", 4, 32'h100, 32'd4, 32'h2222_0000, 1'b0);
    if (obsCyc.size() >= 4) checkOutput("t2_bAfterLast", 32'(bEdge > obsCyc[3]), 32'd1);
    checkOutput("t2_bcount", 32'(bCount), 32'd2);
    checkOutput("t2_bresp", 32'(lastBresp), 32'(AXI_RESP_OKAY));
    rdyMode = 0;

    // Test 3: FIXED 0x40, 8 beats, varying strobes.
    $display("[TB] test 3: FIXED burst");
    clearObs();
    applyStimulus(32'h40, 7, 3'd2, AXI_BURST_FIXED, 7, 32'h3333_0000, 1'b1);
    checkBeats("t3", 8, 32'h40, 32'd0, 32'h3333_0000, 1'b1);
    checkOutput("t3_bresp", 32'(lastBresp), 32'(AXI_RESP_OKAY));

    // Test 4a: early wlast on beat 2.
    $display("[TB] test 4: error responses");
    clearObs();
    applyStimulus(32'h80, 3, 3'd2, AXI_BURST_INCR, 2, 32'h4444_0000, 1'b0);
    checkBeats("t4a", 4, 32'h80, 32'd4, 32'h4444_0000, 1'b0);
    checkOutput("t4a_bresp", 32'(lastBresp), 32'(AXI_RESP_SLVERR));

    // Test 4b: awsize=3 wider than the bus, no writes forwarded.
    clearObs();
    applyStimulus(32'h80, 3, 3'd3, AXI_BURST_INCR, 3, 32'h4545_0000, 1'b0);
    checkOutput("t4b_noWrites", 32'(obsAddr.size()), 32'd0);
    checkOutput("t4b_bresp", 32'(lastBresp), 32'(AXI_RESP_SLVERR));

    // Test 4c: WRAP is walked as INCR but flagged.
    clearObs();
    applyStimulus(32'h20, 3, 3'd2, AXI_BURST_WRAP, 3, 32'h4646_0000, 1'b0);
    checkBeats("t4c", 4, 32'h20, 32'd4, 32'h4646_0000, 1'b0);
    checkOutput("t4c_bresp", 32'(lastBresp), 32'(AXI_RESP_SLVERR));

    // Test 6: reset after two beats of a four-beat burst.
    $display("[TB] test 6: reset mid-burst");
    bBefore = bCount;
    applyAw(32'h200, 8'd3, 3'd2, AXI_BURST_INCR);
    applyBeat(32'h6666_0000, 4'hF, 1'b0);
    applyBeat(32'h6666_0001, 4'hF, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("t6_awready", 32'(awready), 32'd0);
    checkOutput("t6_wready", 32'(wready), 32'd0);
    checkOutput("t6_bvalid", 32'(bvalid), 32'd0);
    checkOutput("t6_wrvld", 32'(wrvld), 32'd0);
    checkOutput("t6_wraddr", wraddr, 32'd0);
    checkOutput("t6_wrdata", wrdata, 32'd0);
    checkOutput("t6_wrbe", 32'(wrbe), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("t6_noB", 32'(bCount), 32'(bBefore));
    clearObs();
    applyStimulus(32'h300, 3, 3'd2, AXI_BURST_INCR, 3, 32'h6767_0000, 1'b0);
    checkBeats("t6_next", 4, 32'h300, 32'd4, 32'h6767_0000, 1'b0);
    checkOutput("t6_bresp", 32'(lastBresp), 32'(AXI_RESP_OKAY));

    // Test 5: 200 words from 0x0 in bursts of at most 64, slow B acceptor.
    $display("[TB] test 5: 200-word stream");
    bMode    = 1;
    holdViol = 0;
    bBefore  = bCount;
    clearObs();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'(k * 256), (k < 3) ? 63 : 7, 3'd2, AXI_BURST_INCR,
                    (k < 3) ? 63 : 7, 32'hD000_0000 + 32'(k * 64), 1'b0);
    end
    checkBeats("t5", 200, 32'h0, 32'd4, 32'hD000_0000, 1'b0);
    checkOutput("t5_bcount", 32'(bCount - bBefore), 32'd4);
    checkOutput("t5_bHold", 32'(holdViol), 32'd0);
    checkOutput("t5_bresp", 32'(lastBresp), 32'(AXI_RESP_OKAY));
    bMode = 0;

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
